// File: rtl/lfsr_prng_checker.sv
// Receive-side checker for the 64-bit XNOR LFSR stream: syncs a shadow copy from bit 0
// of the observed samples, then flywheels it and counts mismatches. Option: LFSR_PRNG_CHECKER_SEED_EN.
module lfsr_prng_checker #(
  parameter int SIZE       = 3,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LFSR_PRNG_CHECKER_SEED_EN
  input  logic [63:0]      seed_i,
`endif
  input  logic             valid_i,
  input  logic [SIZE-1:0]  sample_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [SIZE-1:0]  expected_o
);

  typedef enum logic {SYNC, LOCKED} state_t;

  localparam logic [8:0] THR = 9'(ERR_THRESH);

  state_t            state_q, state_d;
  logic [63:0]       shadow_q, shadow_d, adv;
  logic [6:0]        fill_q, fill_d;
  logic [7:0]        consec_q, consec_d;
  logic              first_q, first_d;
  logic              mis_d;
  logic [SIZE-1:0]   exp_d, pred;
  logic [CNT_W-1:0]  cnt_d;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  assign adv      = lfsr_next(shadow_q);
  // A seeded reset leaves the shadow equal to the generator's current output, not its successor.
  assign pred     = first_q ? shadow_q[SIZE-1:0] : adv[SIZE-1:0];
  assign locked_o = (state_q == LOCKED);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    fill_d   = fill_q;
    consec_d = consec_q;
    first_d  = first_q;
    mis_d    = 1'b0;
    exp_d    = expected_o;
    cnt_d    = clear_i ? '0 : err_cnt_o;
    if (valid_i) begin
      case (state_q)
        SYNC: begin
          shadow_d = {shadow_q[62:0], sample_i[0]};
          fill_d   = fill_q + 7'd1;
          if (fill_q == 7'd63) state_d = LOCKED;
        end
        LOCKED: begin
          first_d = 1'b0;
          if (!first_q) shadow_d = adv;
          exp_d = pred;
          if (sample_i != pred) begin
            mis_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
            if ({1'b0, consec_q} + 9'd1 >= THR) begin
              state_d  = SYNC;
              fill_d   = '0;
              consec_d = '0;
            end else begin
              consec_d = consec_q + 8'd1;
            end
          end else begin
            consec_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef LFSR_PRNG_CHECKER_SEED_EN
      state_q  <= LOCKED;
      shadow_q <= seed_i;
      first_q  <= 1'b1;
`else
      state_q  <= SYNC;
      shadow_q <= '0;
      first_q  <= 1'b0;
`endif
      fill_q     <= '0;
      consec_q   <= '0;
      mismatch_o <= 1'b0;
      expected_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      first_q    <= first_d;
      fill_q     <= fill_d;
      consec_q   <= consec_d;
      mismatch_o <= mis_d;
      expected_o <= exp_d;
      err_cnt_o  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_prng_checker.sv
// Bench for lfsr_prng_checker: a reference generator drives two DUTs (CNT_W=16 and 2),
// a queue-based model predicts outputs each cycle, and literal checks pin the model.
module tb_lfsr_prng_checker;
  localparam int SIZE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [SIZE-1:0] sample = '0;
  logic clear = 1'b0;
  logic [63:0] seed = '0;
  logic locked, mis, locked_s, mis_s;
  logic [15:0] err;
  logic [1:0] err_s;
  logic [SIZE-1:0] expv, expv_s;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  lfsr_prng_checker #(.SIZE(SIZE), .ERR_THRESH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
`ifdef LFSR_PRNG_CHECKER_SEED_EN
    .seed_i(seed),
`endif
    .valid_i(valid), .sample_i(sample), .clear_i(clear),
    .locked_o(locked), .mismatch_o(mis), .err_cnt_o(err), .expected_o(expv));

  lfsr_prng_checker #(.SIZE(SIZE), .ERR_THRESH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
`ifdef LFSR_PRNG_CHECKER_SEED_EN
    .seed_i(seed),
`endif
    .valid_i(valid), .sample_i(sample), .clear_i(clear),
    .locked_o(locked_s), .mismatch_o(mis_s), .err_cnt_o(err_s), .expected_o(expv_s));

  function automatic logic [63:0] nxt(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Model: in sync it just remembers the observed bit-0 history; the generator state is
  // the last 64 of those bits read as a word (newest bit = bit 0).
  bit          hist[$];
  bit          m_locked, m_first, m_mis;
  logic [63:0] m_state;
  logic [SIZE-1:0] m_exp, pe;
  int          m_err, m_consec;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
`ifdef LFSR_PRNG_CHECKER_SEED_EN
      m_locked = 1; m_first = 1; m_state = seed;
`else
      m_locked = 0; m_first = 0; m_state = '0;
`endif
      m_mis = 0; m_exp = '0; m_err = 0; m_consec = 0;
    end else begin
      m_mis = 0;
      if (clear) m_err = 0;
      if (valid) begin
        if (!m_locked) begin
          hist.push_back(sample[0]);
          if (hist.size() == 64) begin
            for (int j = 0; j < 64; j++) m_state[j] = hist[63-j];
            m_locked = 1;
          end
        end else begin
          if (!m_first) m_state = nxt(m_state);
          m_first = 0;
          pe = m_state[SIZE-1:0];
          m_exp = pe;
          if (sample != pe) begin
            m_mis = 1; m_err++; m_consec++;
            if (m_consec >= 4) begin
              m_locked = 0; m_consec = 0; hist.delete();
            end
          end else m_consec = 0;
        end
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", 64'(locked), 64'(m_locked));
      chk("mismatch", 64'(mis), 64'(m_mis));
      chk("err_cnt", 64'(err), 64'(sat(m_err, 65535)));
      chk("expected", 64'(expv), 64'(m_exp));
      chk("locked_s", 64'(locked_s), 64'(m_locked));
      chk("err_cnt_s", 64'(err_s), 64'(sat(m_err, 3)));
    end
  end

  logic [63:0] g;

  task automatic step(input bit v, input logic [SIZE-1:0] s, input bit c);
    @(negedge clk);
    valid = v; sample = s; clear = c;
    @(posedge clk); #1;
    valid = 0; clear = 0;
  endtask

  task automatic gen(input logic [SIZE-1:0] x, input bit c);
    step(1'b1, g[SIZE-1:0] ^ x, c);
    g = nxt(g);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  logic [1:0] small_want [5];

  initial begin
    small_want[0] = 2'd1; small_want[1] = 2'd2; small_want[2] = 2'd3;
    small_want[3] = 2'd3; small_want[4] = 2'd3;
    @(posedge clk); #1;
    rst = 0; cmp_en = 1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_expected", 64'(expv), 64'd0);

`ifndef LFSR_PRNG_CHECKER_SEED_EN
    // Generator seeded 0: first outputs 0,1,3,7.
    g = '0;
    chk("gen_s0", 64'(g[2:0]), 64'd0); g = nxt(g);
    chk("gen_s1", 64'(g[2:0]), 64'd1); g = nxt(g);
    chk("gen_s2", 64'(g[2:0]), 64'd3); g = nxt(g);
    chk("gen_s3", 64'(g[2:0]), 64'd7);
    g = '0;
    for (int i = 0; i < 63; i++) gen('0, 0);
    chk("locked_at63", 64'(locked), 64'd0);
    gen('0, 0);
    chk("locked_at64", 64'(locked), 64'd1);
    gen('0, 0);
    chk("first_pred", 64'(expv), 64'd6);
    for (int i = 0; i < 99; i++) gen('0, 0);
    chk("clean_err", 64'(err), 64'd0);

    // Scattered single mismatches.
    for (int k = 0; k < 5; k++) begin
      gen(3'b001, 0);
      chk("single_mis", 64'(mis), 64'd1);
      chk("single_locked", 64'(locked), 64'd1);
      chk("scatter_err", 64'(err), 64'(k + 1));
      chk("scatter_err_s", 64'(err_s), 64'(small_want[k]));
      gen('0, 0);
      chk("after_mis", 64'(mis), 64'd0);
      gen('0, 0);
    end
    gen(3'b010, 1);
    chk("clear_with_mis", 64'(err), 64'd1);
    chk("clear_with_mis_s", 64'(err_s), 64'd1);
    gen('0, 0);
    gen('0, 1);
    chk("clear_clean", 64'(err), 64'd0);

    // Burst of 4 mismatches drops lock; 64 clean samples re-lock.
    for (int i = 0; i < 3; i++) gen(3'b100, 0);
    chk("burst3_locked", 64'(locked), 64'd1);
    gen(3'b100, 0);
    chk("burst_err", 64'(err), 64'd4);
    chk("burst_unlock", 64'(locked), 64'd0);
    for (int i = 0; i < 63; i++) gen('0, 0);
    chk("relock63", 64'(locked), 64'd0);
    gen('0, 0);
    chk("relock64", 64'(locked), 64'd1);

    // Valid gap, then resume the stream.
    for (int i = 0; i < 10; i++) step(1'b0, 3'b111, 0);
    for (int i = 0; i < 5; i++) gen('0, 0);
    chk("gap_err", 64'(err), 64'd4);
    gen(3'b001, 0);
    step(1'b0, '0, 0);
    chk("gap_forces_mis0", 64'(mis), 64'd0);
    do_reset();
    chk("midreset_locked", 64'(locked), 64'd0);
    chk("midreset_err", 64'(err), 64'd0);
    for (int i = 0; i < 8; i++) gen('0, 0);
`else
    seed = 64'h0;
    do_reset();
    chk("seed0_locked", 64'(locked), 64'd1);
    g = '0;
    for (int i = 0; i < 4; i++) begin
      gen('0, 0);
      chk("seed0_mis", 64'(mis), 64'd0);
    end
    chk("seed0_expected", 64'(expv), 64'd7);
    chk("seed0_err", 64'(err), 64'd0);
    seed = 64'h1;
    do_reset();
    g = '0;
    gen('0, 0);
    chk("seed1_mis", 64'(mis), 64'd1);
    chk("seed1_err", 64'(err), 64'd1);
    for (int i = 0; i < 8; i++) gen('0, 0);
    chk("seed1_fallback", 64'(locked), 64'd0);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lfsr_prng_checker.md
Name: lfsr_prng_checker

Overview:
- Receive-side checker for the 64-bit XNOR LFSR random-number stream (taps 64,63,61,60; shift-left; new bit enters at bit 0; all-zero state valid).
- Observes the SIZE-bit number the generator emits each step, self-synchronises by shifting in the newest bit, then flywheels its own LFSR copy and flags mismatches.
- Used in IFU randomised-placement/replacement paths to prove the PRNG stream is intact and in step.

Parameters:
- SIZE, 3, width of observed sample; legal range 1..64.
- ERR_THRESH, 4, consecutive mismatches in LOCKED that force loss of lock; legal range 1..255.
- CNT_W, 16, width of the saturating total-error counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  sample_i is valid this cycle; exactly one generator step per valid.
- sample_i  input  SIZE  observed generator output (generator state bits [SIZE-1:0]).
- clear_i  input  1  synchronous clear of err_cnt_o only.
- locked_o  output  1  checker in LOCKED state.
- mismatch_o  output  1  one-cycle pulse, registered: previous valid sample mismatched.
- err_cnt_o  output  CNT_W  saturating count of mismatches since reset/clear.
- expected_o  output  SIZE  registered: value compared against the last valid sample.

Behaviour:
- State: shadow[63:0], fill counter [6:0], consec counter [7:0], FSM {SYNC, LOCKED}.
- next(s) = {s[62:0], ~(s[63]^s[62]^s[60]^s[59])}.
- Reset, synchronous, active-high:
  - FSM=SYNC; shadow=0; fill=0; consec=0.
  - All outputs 0.
  - Reset dominates every other input in the same cycle.
- valid_i=0: no state or output change, except that mismatch_o is forced to 0. Gaps of any length are allowed.
- SYNC, valid_i=1:
  - shadow <= {shadow[62:0], sample_i[0]}; fill++.
  - No comparison; mismatch_o=0.
  - On the 64th valid sample (fill==63), FSM <= LOCKED. locked_o=1 from the next cycle.
- LOCKED, valid_i=1:
  - exp = next(shadow)[SIZE-1:0]; shadow <= next(shadow), i.e. flywheel with no resync from input.
  - expected_o <= exp.
  - mismatch_o <= (sample_i != exp).
  - On match: consec <= 0.
  - On mismatch: err_cnt_o++ (saturates at 2^CNT_W-1); consec++.
  - If consec reaches ERR_THRESH on this sample: FSM <= SYNC, fill <= 0, consec <= 0, and locked_o drops the next cycle.
- Latency: mismatch_o, expected_o and err_cnt_o update 1 cycle after the valid sample.
- clear_i with a mismatch in the same cycle: err_cnt_o <= 1 (clear first, then count). clear_i does not affect the FSM.
- All-ones shadow is the XNOR lockup state. It is predicted normally with no special case; the generator never reaches it from a legal seed.
- Reset mid-LOCKED: returns to SYNC with all counters zeroed. err_cnt_o is not preserved.

Optional Feature:
- Macro: LFSR_PRNG_CHECKER_SEED_EN.
- Defined:
  - Adds input seed_i[63:0].
  - Reset loads shadow=seed_i and sets FSM=LOCKED (locked_o=1 after reset) with first flag=1.
  - While first=1, the first valid sample compares against shadow[SIZE-1:0] without advancing shadow, then clears first. This matches a generator reset with the same seed.
  - Loss of lock still falls back to SYNC.
- Not defined: no seed_i port; reset always enters SYNC as above.

Test Plan:
- Seed 0, no macro: drive 64 valid samples of a reference generator seeded 0 (first samples 0,1,3,7,7,7...) -> locked_o=0 through the 64th sample, 1 the cycle after; following 100 samples give mismatch_o=0, err_cnt_o=0.
- Locked, corrupt one sample (XOR with 3'b001) -> mismatch_o single pulse, err_cnt_o=1, locked_o stays 1; next correct sample gives mismatch_o=0.
- Locked, 4 consecutive corrupted samples (ERR_THRESH=4) -> err_cnt_o=4, locked_o=0 next cycle; 64 clean samples later locked_o=1 again.
- CNT_W=2, 5 scattered single mismatches -> err_cnt_o 1,2,3,3,3. clear_i asserted together with a mismatch -> err_cnt_o=1.
- Valid gaps: deassert valid_i for 10 cycles mid-LOCKED, then resume the stream -> no mismatches. Assert rst mid-LOCKED -> locked_o=0, err_cnt_o=0 next cycle.
- Macro defined, seed_i=64'h0: rst then samples 0,1,3,7 -> locked_o=1 from reset release, mismatch_o=0. Same run with seed_i=64'h1 -> first-sample mismatch, err_cnt_o=1.
